// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI configuration slave:
//   - spi_state_t     : FSM state encodings (IDLE, LOAD, SHIFT)
//   - EDGE_RISE/FALL  : edge-select constants
//   - sample_edge_sel : picks which SCLK edge samples MOSI for a CPOL/CPHA pair
// -----------------------------------------------------------------------------
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } spi_state_t;

  localparam logic EDGE_RISE = 1'b1;
  localparam logic EDGE_FALL = 1'b0;

  // The leading edge is rising for CPOL=0 and falling for CPOL=1. CPHA=0
  // samples on the leading edge, CPHA=1 on the trailing edge, so the sample
  // edge is rising exactly when CPOL and CPHA agree.
  function automatic logic sample_edge_sel(input logic cpol, input logic cpha);
    logic sel_v;
    if (cpol == cpha) begin
      sel_v = EDGE_RISE;
    end else begin
      sel_v = EDGE_FALL;
    end
    return sel_v;
  endfunction

endpackage

// File: rtl/spi_sync.sv
// -----------------------------------------------------------------------------
// spi_sync
// Two-flop synchroniser followed by a history flop and registered edge pulses
// for one asynchronous pin. A pin change is reflected on level/rise/fall three
// clk edges later; level and the edge pulses change on the same edge, so
// they stay mutually consistent for the consumer.
// Ports:
//   clk   : system clock
//   rst   : synchronous active-high reset (flops go to RST_VAL, pulses to 0)
//   din   : asynchronous pin
//   level : synchronised pin level (history flop)
//   rise  : one-cycle pulse on a synchronised 0->1 transition
//   fall  : one-cycle pulse on a synchronised 1->0 transition
// -----------------------------------------------------------------------------
module spi_sync
  import spi_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta_r;
  logic sync_r;
  logic hist_r;
  logic rise_r;
  logic fall_r;

  // Synchroniser chain, history flop and registered edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_r <= RST_VAL;
      sync_r <= RST_VAL;
      hist_r <= RST_VAL;
      rise_r <= 1'b0;
      fall_r <= 1'b0;
    end else begin
      meta_r <= din;
      sync_r <= meta_r;
      hist_r <= sync_r;
      rise_r <= sync_r & ~hist_r;
      fall_r <= ~sync_r & hist_r;
    end
  end

  assign level = hist_r;
  assign rise  = rise_r;
  assign fall  = fall_r;

endmodule

// File: rtl/spi_slave_cfg.sv
// -----------------------------------------------------------------------------
// spi_slave_cfg
// Parameterisable SPI slave (all four CPOL/CPHA modes, MSB- or LSB-first)
// running entirely in the clk domain. SCLK, MOSI and SEL_ are oversampled
// through spi_sync; SCLK half-period must be at least 4 clk cycles.
// Ports:
//   clk, rst     : clock and synchronous active-high reset
//   ucSCLK       : SPI clock from the master (asynchronous)
//   ucMOSI       : serial data from the master
//   ucSEL_       : active-low chip select
//   ucMISO       : serial data to the master (0 when not enabled)
//   ucMISO_oe    : MISO output enable, high while selected
//   data_in      : next word to transmit, captured in LOAD
//   tx_ack       : one-cycle pulse when data_in is captured
//   data_out     : last complete received word
//   rx_valid     : one-cycle pulse when data_out updates
//   frame_err    : one-cycle pulse when a partial word is deselected
//   busy         : high while the FSM is not idle
// -----------------------------------------------------------------------------
module spi_slave_cfg
  import spi_pkg::*;
#(
  parameter int WIDTH     = 32'd8,
  parameter int CPOL      = 32'd0,
  parameter int CPHA      = 32'd0,
  parameter int MSB_FIRST = 32'd1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ucSCLK,
  input  logic             ucMOSI,
  input  logic             ucSEL_,
  output logic             ucMISO,
  output logic             ucMISO_oe,
  input  logic [WIDTH-1:0] data_in,
  output logic             tx_ack,
  output logic [WIDTH-1:0] data_out,
  output logic             rx_valid,
  output logic             frame_err,
  output logic             busy
);

  localparam int               CNT_W       = (WIDTH > 32'd2) ? $clog2(WIDTH) : 32'd1;
  localparam logic [CNT_W-1:0] LAST_BIT    = CNT_W'(WIDTH - 32'd1);
  localparam logic             SAMPLE_EDGE = sample_edge_sel(CPOL != 32'd0, CPHA != 32'd0);

  // Next bit to present on MISO from the tx shift register.
  function automatic logic tx_bit(input logic [WIDTH-1:0] sr);
    logic b_v;
    if (MSB_FIRST != 32'd0) begin
      b_v = sr[WIDTH-1];
    end else begin
      b_v = sr[0];
    end
    return b_v;
  endfunction

  // Tx shift register after removing the bit just presented.
  function automatic logic [WIDTH-1:0] tx_shift(input logic [WIDTH-1:0] sr);
    logic [WIDTH-1:0] s_v;
    if (MSB_FIRST != 32'd0) begin
      s_v = {sr[WIDTH-2:0], 1'b0};
    end else begin
      s_v = {1'b0, sr[WIDTH-1:1]};
    end
    return s_v;
  endfunction

  // Rx shift register with one more sampled bit appended in wire order.
  function automatic logic [WIDTH-1:0] rx_shift(input logic [WIDTH-1:0] sr, input logic b);
    logic [WIDTH-1:0] s_v;
    if (MSB_FIRST != 32'd0) begin
      s_v = {sr[WIDTH-2:0], b};
    end else begin
      s_v = {b, sr[WIDTH-1:1]};
    end
    return s_v;
  endfunction

  // Synchronised pin views.
  logic sclk_lvl_s, sclk_rise_s, sclk_fall_s;
  logic mosi_lvl_s, mosi_rise_s, mosi_fall_s;
  logic sel_lvl_s,  sel_rise_s,  sel_fall_s;
  logic sample_s;
  logic shift_s;
  logic unused_s;

  // FSM and datapath state.
  spi_state_t       state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] tx_sr_r;
  logic [WIDTH-1:0] rx_sr_r;
  logic [WIDTH-1:0] data_out_r;
  logic             miso_r;
  logic             tx_ack_r;
  logic             rx_valid_r;
  logic             frame_err_r;
  logic             busy_r;
  logic [1:0]       flush_cnt_r;
  logic             armed_r;

  spi_sync #(.RST_VAL(CPOL != 32'd0)) u_sync_sclk (
    .clk   (clk),
    .rst   (rst),
    .din   (ucSCLK),
    .level (sclk_lvl_s),
    .rise  (sclk_rise_s),
    .fall  (sclk_fall_s)
  );

  spi_sync #(.RST_VAL(1'b0)) u_sync_mosi (
    .clk   (clk),
    .rst   (rst),
    .din   (ucMOSI),
    .level (mosi_lvl_s),
    .rise  (mosi_rise_s),
    .fall  (mosi_fall_s)
  );

  spi_sync #(.RST_VAL(1'b1)) u_sync_sel (
    .clk   (clk),
    .rst   (rst),
    .din   (ucSEL_),
    .level (sel_lvl_s),
    .rise  (sel_rise_s),
    .fall  (sel_fall_s)
  );

  // Pin views that this block has no use for.
  assign unused_s = &{1'b0, sclk_lvl_s, mosi_rise_s, mosi_fall_s, sel_rise_s};

  assign sample_s = (SAMPLE_EDGE == EDGE_RISE) ? sclk_rise_s : sclk_fall_s;
  assign shift_s  = (SAMPLE_EDGE == EDGE_RISE) ? sclk_fall_s : sclk_rise_s;

  // Re-arm gate: after reset the SEL_ synchroniser starts at 1, so a select
  // held low across reset would look like a new falling edge. Only accept a
  // falling edge once the chain has flushed and SEL_ has really been high.
  always_ff @(posedge clk) begin
    if (rst) begin
      flush_cnt_r <= 2'd0;
      armed_r     <= 1'b0;
    end else begin
      if (flush_cnt_r != 2'd3) begin
        flush_cnt_r <= flush_cnt_r + 2'd1;
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
      armed_r <= armed_r | ((flush_cnt_r == 2'd3) & sel_lvl_s);
    end
  end

  // Main FSM: IDLE -> LOAD -> SHIFT (-> LOAD per word), deselect -> IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      cnt_r       <= '0;
      tx_sr_r     <= '0;
      rx_sr_r     <= '0;
      data_out_r  <= '0;
      miso_r      <= 1'b0;
      tx_ack_r    <= 1'b0;
      rx_valid_r  <= 1'b0;
      frame_err_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      tx_ack_r    <= 1'b0;
      rx_valid_r  <= 1'b0;
      frame_err_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          // SCLK activity is ignored here; only a fresh select starts a frame.
          if (sel_fall_s && armed_r) begin
            state_r <= ST_LOAD;
            busy_r  <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (sel_lvl_s) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            cnt_r   <= '0;
            rx_sr_r <= '0;
            miso_r  <= 1'b0;
          end else begin
            tx_ack_r <= 1'b1;
            cnt_r    <= '0;
            state_r  <= ST_SHIFT;
            if (CPHA == 32'd0) begin
              // First bit must already be on the wire for the leading edge.
              miso_r  <= tx_bit(data_in);
              tx_sr_r <= tx_shift(data_in);
            end else begin
              // First bit goes out on the first leading edge.
              tx_sr_r <= data_in;
            end
          end
        end
        ST_SHIFT: begin
          if (sel_lvl_s) begin
            // A deselect landing on the final sample still completes the word.
            if (sample_s && (cnt_r == LAST_BIT)) begin
              data_out_r <= rx_shift(rx_sr_r, mosi_lvl_s);
              rx_valid_r <= 1'b1;
            end else if (cnt_r != '0) begin
              frame_err_r <= 1'b1;
            end else begin
              frame_err_r <= 1'b0;
            end
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            cnt_r   <= '0;
            rx_sr_r <= '0;
            miso_r  <= 1'b0;
          end else begin
            if (sample_s) begin
              rx_sr_r <= rx_shift(rx_sr_r, mosi_lvl_s);
              if (cnt_r == LAST_BIT) begin
                data_out_r <= rx_shift(rx_sr_r, mosi_lvl_s);
                rx_valid_r <= 1'b1;
                cnt_r      <= '0;
                state_r    <= ST_LOAD;
              end else begin
                cnt_r <= cnt_r + CNT_W'(1);
              end
            end else begin
              rx_sr_r <= rx_sr_r;
            end
            // With CPHA=0 the trailing edge that follows the previous word's
            // last sample arrives after LOAD; cnt_r==0 marks it as stale.
            if (shift_s && ((CPHA != 32'd0) || (cnt_r != '0))) begin
              miso_r  <= tx_bit(tx_sr_r);
              tx_sr_r <= tx_shift(tx_sr_r);
            end else begin
              miso_r <= miso_r;
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          cnt_r   <= '0;
          rx_sr_r <= '0;
          miso_r  <= 1'b0;
        end
      endcase
    end
  end

  assign ucMISO_oe = ~sel_lvl_s;
  assign ucMISO    = miso_r & ~sel_lvl_s;
  assign tx_ack    = tx_ack_r;
  assign data_out  = data_out_r;
  assign rx_valid  = rx_valid_r;
  assign frame_err = frame_err_r;
  assign busy      = busy_r;

endmodule

// File: doc/spi_slave_cfg.md
SPI_SLAVE_CFG -- requirements
Module: spi_slave_cfg

Interface
REQ-001 SHALL have parameter WIDTH, default 8: word length in bits, legal range 2..32.
REQ-002 SHALL have parameter CPOL, default 0: SCLK idle level.
REQ-003 SHALL have parameter CPHA, default 0: 0 = sample on leading edge, 1 = sample on trailing edge.
REQ-004 SHALL have parameter MSB_FIRST, default 1: 1 = MSB shifted first, 0 = LSB first.
REQ-005 SHALL have port clk, input, 1 bit: the only clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port ucSCLK, input, 1 bit: SPI clock, asynchronous to clk.
REQ-008 SHALL have port ucMOSI, input, 1 bit: serial data from the master.
REQ-009 SHALL have port ucSEL_, input, 1 bit: active-low chip select.
REQ-010 SHALL have port ucMISO, output, 1 bit: serial data to the master.
REQ-011 SHALL have port ucMISO_oe, output, 1 bit: MISO output enable, high while selected.
REQ-012 SHALL have port data_in, input, WIDTH bits: next word to transmit.
REQ-013 SHALL have port tx_ack, output, 1 bit: one-cycle pulse when data_in is captured.
REQ-014 SHALL have port data_out, output, WIDTH bits: last complete received word.
REQ-015 SHALL have port rx_valid, output, 1 bit: one-cycle pulse when data_out updates.
REQ-016 SHALL have port frame_err, output, 1 bit: one-cycle pulse on partial-word deselect.
REQ-017 SHALL have port busy, output, 1 bit: high while not in IDLE.

Function
REQ-018 SHALL pass ucSCLK, ucMOSI and ucSEL_ through 2-flop synchronisers, then one history flop for edge detection; pin-to-edge-detect latency is 3 clk cycles.
REQ-019 SHALL define leading edge as rising when CPOL=0 and falling when CPOL=1; the trailing edge is the opposite edge.
REQ-020 SHALL implement FSM IDLE -> LOAD -> SHIFT; SHIFT -> LOAD after the last bit; any state -> IDLE on synchronised SEL_ high.
REQ-021 SHALL leave IDLE on the synchronised SEL_ falling edge, entering LOAD.
REQ-022 SHALL, in LOAD (exactly one cycle), copy data_in into the tx shift register, pulse tx_ack, clear the bit counter, and enter SHIFT.
REQ-023 SHALL present ucMISO as the first tx bit (MSB if MSB_FIRST, else LSB) when CPHA=0 and drive it from LOAD onward.
REQ-024 SHALL sample MOSI into the rx shift register on the sample edge and advance ucMISO to the next bit on the opposite edge; with CPHA=1 the first tx bit is driven on the first leading edge.
REQ-025 SHALL count sampled bits modulo WIDTH; on the WIDTH-th sample, copy the assembled word to data_out, assert rx_valid on the next cycle, and enter LOAD for the next word.
REQ-026 SHALL support back-to-back words within one select with no gap; the LOAD cycle completes before the next master edge, provided SCLK half-period is at least 4 clk cycles.
REQ-027 SHALL, on SEL_ deassertion with bit counter nonzero, pulse frame_err, discard the partial word, and leave data_out unchanged.
REQ-028 SHALL treat SEL_ deassertion coincident with the WIDTH-th sample as a complete word: rx_valid pulses and frame_err does not.
REQ-029 SHALL ignore SCLK edges while in IDLE.
REQ-030 SHALL drive ucMISO_oe as the inverted synchronised SEL_; ucMISO is 0 when ucMISO_oe is low.

Reset
REQ-031 SHALL, when rst is high at a clk edge, force IDLE, set the counter to 0, clear both shift registers and data_out, and drive tx_ack, rx_valid, frame_err, busy, ucMISO and ucMISO_oe to 0.
REQ-032 SHALL reset the synchroniser flops to the inactive level: SEL_ = 1 and SCLK = CPOL.
REQ-033 SHALL, on reset mid-frame, require a fresh SEL_ falling edge before resuming, and SHALL NOT flag frame_err.

Structure
REQ-034 SHALL place the FSM state encodings and the edge-select helper constants in shared package spi_pkg.
REQ-035 SHALL instantiate the sub-module spi_sync (2-flop synchroniser plus edge detector, output rise and fall pulses) once per input pin.

Verification
REQ-036 Mode 0, WIDTH=8, MSB first: master sends 0xA5 while data_in=0x3C -> MISO stream 0x3C, data_out=0xA5, one rx_valid pulse, one tx_ack pulse.
REQ-037 Modes 1, 2 and 3, each tested: same transfer -> identical data_out and MISO stream.
REQ-038 Two back-to-back words 0x12, 0x34 in one select, with data_in changed after the first tx_ack -> two rx_valid pulses and two tx_ack pulses, MISO carries both words.
REQ-039 Deselect after 5 bits -> frame_err pulses once, no rx_valid, data_out holds its previous value.
REQ-040 WIDTH=16, MSB_FIRST=0, transfer 0xBEEF -> data_out=0xBEEF, LSB observed first on MISO.
REQ-041 rst asserted after 3 bits of a transfer -> all outputs 0 the next cycle; later edges ignored until a new select; next full word is received correctly.
